// File: rtl/int_issue_queue_select_if.sv
// Dispatch-to-scheduler bundle for the integer issue queue: dispatch writes,
// wakeup broadcasts, issue-side stall/flush and the issue/release return path.
interface int_issue_queue_select_if #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int ENTRY_NUM      = 16,
  parameter int PTR_WIDTH      = 4,
  parameter int PREG_WIDTH     = 7,
  parameter int WAKEUP_WIDTH   = 2,
  parameter int PAYLOAD_WIDTH  = 96
) ();
  logic                                    flush;
  logic [DISPATCH_WIDTH-1:0]               ds_write;
  logic [DISPATCH_WIDTH*PTR_WIDTH-1:0]     ds_write_ptr;
  logic [DISPATCH_WIDTH-1:0]               ds_src_valid_a;
  logic [DISPATCH_WIDTH-1:0]               ds_src_valid_b;
  logic [DISPATCH_WIDTH-1:0]               ds_src_ready_a;
  logic [DISPATCH_WIDTH-1:0]               ds_src_ready_b;
  logic [DISPATCH_WIDTH*PREG_WIDTH-1:0]    ds_src_tag_a;
  logic [DISPATCH_WIDTH*PREG_WIDTH-1:0]    ds_src_tag_b;
  logic [DISPATCH_WIDTH-1:0]               ds_write_reg;
  logic [DISPATCH_WIDTH*PREG_WIDTH-1:0]    ds_dst_tag;
  logic [DISPATCH_WIDTH*PAYLOAD_WIDTH-1:0] ds_payload;
  logic [WAKEUP_WIDTH-1:0]                 wakeup_valid;
  logic [WAKEUP_WIDTH*PREG_WIDTH-1:0]      wakeup_tag;
  logic                                    issue_stall;
  logic                                    issue_valid;
  logic [PTR_WIDTH-1:0]                    issue_ptr;
  logic [PAYLOAD_WIDTH-1:0]                issue_payload;
  logic                                    release_valid;
  logic [PTR_WIDTH-1:0]                    release_ptr;
  logic [PTR_WIDTH:0]                      occupancy;

  modport master (
    output flush, ds_write, ds_write_ptr, ds_src_valid_a, ds_src_valid_b,
           ds_src_ready_a, ds_src_ready_b, ds_src_tag_a, ds_src_tag_b,
           ds_write_reg, ds_dst_tag, ds_payload, wakeup_valid, wakeup_tag,
           issue_stall,
    input  issue_valid, issue_ptr, issue_payload, release_valid, release_ptr,
           occupancy
  );

  modport slave (
    input  flush, ds_write, ds_write_ptr, ds_src_valid_a, ds_src_valid_b,
           ds_src_ready_a, ds_src_ready_b, ds_src_tag_a, ds_src_tag_b,
           ds_write_reg, ds_dst_tag, ds_payload, wakeup_valid, wakeup_tag,
           issue_stall,
    output issue_valid, issue_ptr, issue_payload, release_valid, release_ptr,
           occupancy
  );
endinterface

// File: rtl/int_issue_queue_select.sv
// Integer issue queue: age-matrix oldest-ready select into one registered issue slot.
// Define ISSUE_QUEUE_SELF_WAKEUP_EN to let a selected producer wake its dependents internally.
module int_issue_queue_select #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int ENTRY_NUM      = 16,
  parameter int PTR_WIDTH      = 4,
  parameter int PREG_WIDTH     = 7,
  parameter int WAKEUP_WIDTH   = 2,
  parameter int PAYLOAD_WIDTH  = 96
) (
  input logic                      clk,
  input logic                      rst,
  int_issue_queue_select_if.slave  bus
);
`ifdef ISSUE_QUEUE_SELF_WAKEUP_EN
  localparam int WK_NUM = WAKEUP_WIDTH + 1;
`else
  localparam int WK_NUM = WAKEUP_WIDTH;
`endif

  logic [ENTRY_NUM-1:0]     valid_r;
  logic [ENTRY_NUM-1:0]     rdy_a_r;
  logic [ENTRY_NUM-1:0]     rdy_b_r;
  logic [PREG_WIDTH-1:0]    src_a_tag_r [ENTRY_NUM];
  logic [PREG_WIDTH-1:0]    src_b_tag_r [ENTRY_NUM];
  logic [PAYLOAD_WIDTH-1:0] payload_r   [ENTRY_NUM];
  // age_r[i][j] set means entry j is older than entry i
  logic [ENTRY_NUM-1:0]     age_r       [ENTRY_NUM];
`ifdef ISSUE_QUEUE_SELF_WAKEUP_EN
  logic [ENTRY_NUM-1:0]     wr_reg_r;
  logic [PREG_WIDTH-1:0]    dst_tag_r   [ENTRY_NUM];
`endif

  logic                     issue_valid_r;
  logic [PTR_WIDTH-1:0]     issue_ptr_r;
  logic [PAYLOAD_WIDTH-1:0] issue_payload_r;
  logic                     release_valid_r;
  logic [PTR_WIDTH-1:0]     release_ptr_r;
  logic [PTR_WIDTH:0]       occ_r;

  logic [ENTRY_NUM-1:0]         cand_s;
  logic [ENTRY_NUM-1:0]         sel_oh_s;
  logic [PTR_WIDTH-1:0]         sel_ptr_s;
  logic                         sel_any_s;
  logic                         sel_fire_s;
  logic [WK_NUM-1:0]            wk_valid_s;
  logic [WK_NUM*PREG_WIDTH-1:0] wk_tags_s;
  logic [ENTRY_NUM-1:0]         ent_hit_a_s;
  logic [ENTRY_NUM-1:0]         ent_hit_b_s;
  logic [DISPATCH_WIDTH-1:0]    wr_en_s;
  logic [PTR_WIDTH-1:0]         wr_ptr_s     [DISPATCH_WIDTH];
  logic [ENTRY_NUM-1:0]         wr_oh_s      [DISPATCH_WIDTH];
  logic [ENTRY_NUM-1:0]         lane_age_s   [DISPATCH_WIDTH];
  logic [DISPATCH_WIDTH-1:0]    lane_rdy_a_s;
  logic [DISPATCH_WIDTH-1:0]    lane_rdy_b_s;
  logic [ENTRY_NUM-1:0]         wr_mask_s;
  logic [PTR_WIDTH:0]           wr_cnt_s;

  function automatic logic tag_hit(
    input logic [PREG_WIDTH-1:0]        tag,
    input logic [WK_NUM-1:0]            v,
    input logic [WK_NUM*PREG_WIDTH-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WK_NUM; w++) begin
      hit = hit | (v[w] && (tags[w*PREG_WIDTH +: PREG_WIDTH] == tag));
    end
    return hit;
  endfunction

  // Oldest-ready select: a candidate wins when no other candidate is older.
  always_comb begin
    cand_s    = valid_r & rdy_a_r & rdy_b_r;
    sel_oh_s  = {ENTRY_NUM{1'b0}};
    sel_ptr_s = {PTR_WIDTH{1'b0}};
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (cand_s[i] && ((age_r[i] & cand_s) == {ENTRY_NUM{1'b0}})) begin
        sel_oh_s[i] = 1'b1;
        sel_ptr_s   = PTR_WIDTH'(i);
      end else begin
        sel_oh_s[i] = 1'b0;
      end
    end
    sel_any_s  = |cand_s;
    sel_fire_s = sel_any_s & ~bus.issue_stall & ~bus.flush;
  end

  // Wakeup broadcast lines seen by both the stored entries and the dispatch lanes.
  always_comb begin
    wk_valid_s = {WK_NUM{1'b0}};
    wk_tags_s  = {(WK_NUM*PREG_WIDTH){1'b0}};
    wk_valid_s[WAKEUP_WIDTH-1:0]            = bus.wakeup_valid;
    wk_tags_s[WAKEUP_WIDTH*PREG_WIDTH-1:0] = bus.wakeup_tag;
`ifdef ISSUE_QUEUE_SELF_WAKEUP_EN
    wk_valid_s[WAKEUP_WIDTH] = sel_fire_s & wr_reg_r[sel_ptr_s];
    wk_tags_s[WAKEUP_WIDTH*PREG_WIDTH +: PREG_WIDTH] = dst_tag_r[sel_ptr_s];
`endif
  end

  // Tag match of every stored source against this cycle's wakeups.
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      ent_hit_a_s[i] = valid_r[i] & tag_hit(src_a_tag_r[i], wk_valid_s, wk_tags_s);
      ent_hit_b_s[i] = valid_r[i] & tag_hit(src_b_tag_r[i], wk_valid_s, wk_tags_s);
    end
  end

  // Dispatch lane decode: slot one-hots, initial readiness and the new age rows.
  always_comb begin
    wr_mask_s = {ENTRY_NUM{1'b0}};
    wr_cnt_s  = {(PTR_WIDTH+1){1'b0}};
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      wr_en_s[l]  = bus.ds_write[l] & ~bus.flush;
      wr_ptr_s[l] = bus.ds_write_ptr[l*PTR_WIDTH +: PTR_WIDTH];
      wr_oh_s[l]  = wr_en_s[l] ? ({{(ENTRY_NUM-1){1'b0}}, 1'b1} << wr_ptr_s[l])
                               : {ENTRY_NUM{1'b0}};
      wr_mask_s   = wr_mask_s | wr_oh_s[l];
      wr_cnt_s    = wr_cnt_s + {{PTR_WIDTH{1'b0}}, wr_en_s[l]};
      lane_rdy_a_s[l] = !bus.ds_src_valid_a[l] || bus.ds_src_ready_a[l] ||
                        tag_hit(bus.ds_src_tag_a[l*PREG_WIDTH +: PREG_WIDTH], wk_valid_s, wk_tags_s);
      lane_rdy_b_s[l] = !bus.ds_src_valid_b[l] || bus.ds_src_ready_b[l] ||
                        tag_hit(bus.ds_src_tag_b[l*PREG_WIDTH +: PREG_WIDTH], wk_valid_s, wk_tags_s);
    end
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      lane_age_s[l] = valid_r;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        lane_age_s[l] = lane_age_s[l] | ((k < l) ? wr_oh_s[k] : {ENTRY_NUM{1'b0}});
      end
    end
  end

  // Entry valid bits: set on dispatch, cleared when the entry is issued or flushed.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_r <= {ENTRY_NUM{1'b0}};
    end else begin
      valid_r <= (valid_r & ~(sel_fire_s ? sel_oh_s : {ENTRY_NUM{1'b0}})) | wr_mask_s;
    end
  end

  // Entry contents, ready tracking and age rows; a newly written slot becomes
  // the youngest, so its column is cleared in every other row.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_a_r <= {ENTRY_NUM{1'b0}};
      rdy_b_r <= {ENTRY_NUM{1'b0}};
`ifdef ISSUE_QUEUE_SELF_WAKEUP_EN
      wr_reg_r <= {ENTRY_NUM{1'b0}};
`endif
      for (int i = 0; i < ENTRY_NUM; i++) begin
        src_a_tag_r[i] <= {PREG_WIDTH{1'b0}};
        src_b_tag_r[i] <= {PREG_WIDTH{1'b0}};
        payload_r[i]   <= {PAYLOAD_WIDTH{1'b0}};
        age_r[i]       <= {ENTRY_NUM{1'b0}};
`ifdef ISSUE_QUEUE_SELF_WAKEUP_EN
        dst_tag_r[i]   <= {PREG_WIDTH{1'b0}};
`endif
      end
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        rdy_a_r[i] <= rdy_a_r[i] | ent_hit_a_s[i];
        rdy_b_r[i] <= rdy_b_r[i] | ent_hit_b_s[i];
        age_r[i]   <= age_r[i] & ~wr_mask_s;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
          if (wr_en_s[l] && (wr_ptr_s[l] == PTR_WIDTH'(i))) begin
            rdy_a_r[i]     <= lane_rdy_a_s[l];
            rdy_b_r[i]     <= lane_rdy_b_s[l];
            age_r[i]       <= lane_age_s[l];
            src_a_tag_r[i] <= bus.ds_src_tag_a[l*PREG_WIDTH +: PREG_WIDTH];
            src_b_tag_r[i] <= bus.ds_src_tag_b[l*PREG_WIDTH +: PREG_WIDTH];
            payload_r[i]   <= bus.ds_payload[l*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
`ifdef ISSUE_QUEUE_SELF_WAKEUP_EN
            wr_reg_r[i]    <= bus.ds_write_reg[l];
            dst_tag_r[i]   <= bus.ds_dst_tag[l*PREG_WIDTH +: PREG_WIDTH];
`endif
          end
        end
      end
    end
  end

  // Issue register, release pulse and occupancy; the release strobe is a
  // single-cycle event, so it drops while the issue register is stalled.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      issue_valid_r   <= 1'b0;
      issue_ptr_r     <= {PTR_WIDTH{1'b0}};
      issue_payload_r <= {PAYLOAD_WIDTH{1'b0}};
      release_valid_r <= 1'b0;
      release_ptr_r   <= {PTR_WIDTH{1'b0}};
      occ_r           <= {(PTR_WIDTH+1){1'b0}};
    end else begin
      occ_r <= occ_r + wr_cnt_s - {{PTR_WIDTH{1'b0}}, sel_fire_s};
      if (!bus.issue_stall) begin
        issue_valid_r   <= sel_any_s;
        release_valid_r <= sel_any_s;
        if (sel_any_s) begin
          issue_ptr_r     <= sel_ptr_s;
          issue_payload_r <= payload_r[sel_ptr_s];
          release_ptr_r   <= sel_ptr_s;
        end
      end else begin
        release_valid_r <= 1'b0;
      end
    end
  end

  assign bus.issue_valid   = issue_valid_r;
  assign bus.issue_ptr     = issue_ptr_r;
  assign bus.issue_payload = issue_payload_r;
  assign bus.release_valid = release_valid_r;
  assign bus.release_ptr   = release_ptr_r;
  assign bus.occupancy     = occ_r;

  int_issue_queue_select_chk #(
    .DISPATCH_WIDTH (DISPATCH_WIDTH),
    .ENTRY_NUM      (ENTRY_NUM),
    .PTR_WIDTH      (PTR_WIDTH),
    .PREG_WIDTH     (PREG_WIDTH)
  ) u_chk (
    .clk            (clk),
    .rst            (rst),
    .flush          (bus.flush),
    .ds_write       (bus.ds_write),
    .ds_write_ptr   (bus.ds_write_ptr),
    .ds_write_reg   (bus.ds_write_reg),
    .ds_src_valid_a (bus.ds_src_valid_a),
    .ds_src_valid_b (bus.ds_src_valid_b),
    .ds_src_tag_a   (bus.ds_src_tag_a),
    .ds_src_tag_b   (bus.ds_src_tag_b),
    .ds_dst_tag     (bus.ds_dst_tag),
    .valid          (valid_r),
    .occupancy      (occ_r)
  );
endmodule

// Protocol checker: illegal dispatch targets, a renamed destination aliasing
// its own pending source, and occupancy overflow.
module int_issue_queue_select_chk #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int ENTRY_NUM      = 16,
  parameter int PTR_WIDTH      = 4,
  parameter int PREG_WIDTH     = 7
) (
  input logic                                 clk,
  input logic                                 rst,
  input logic                                 flush,
  input logic [DISPATCH_WIDTH-1:0]            ds_write,
  input logic [DISPATCH_WIDTH*PTR_WIDTH-1:0]  ds_write_ptr,
  input logic [DISPATCH_WIDTH-1:0]            ds_write_reg,
  input logic [DISPATCH_WIDTH-1:0]            ds_src_valid_a,
  input logic [DISPATCH_WIDTH-1:0]            ds_src_valid_b,
  input logic [DISPATCH_WIDTH*PREG_WIDTH-1:0] ds_src_tag_a,
  input logic [DISPATCH_WIDTH*PREG_WIDTH-1:0] ds_src_tag_b,
  input logic [DISPATCH_WIDTH*PREG_WIDTH-1:0] ds_dst_tag,
  input logic [ENTRY_NUM-1:0]                 valid,
  input logic [PTR_WIDTH:0]                   occupancy
);
  // Sampled each edge outside reset; flushed writes are discarded and not checked.
  always @(posedge clk) begin
    if (!rst && !flush) begin
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        if (ds_write[l]) begin
          assert (!valid[ds_write_ptr[l*PTR_WIDTH +: PTR_WIDTH]]);
          for (int k = l + 1; k < DISPATCH_WIDTH; k++) begin
            if (ds_write[k]) begin
              assert (ds_write_ptr[l*PTR_WIDTH +: PTR_WIDTH] != ds_write_ptr[k*PTR_WIDTH +: PTR_WIDTH]);
            end
          end
          if (ds_write_reg[l] && ds_src_valid_a[l]) begin
            assert (ds_dst_tag[l*PREG_WIDTH +: PREG_WIDTH] != ds_src_tag_a[l*PREG_WIDTH +: PREG_WIDTH]);
          end
          if (ds_write_reg[l] && ds_src_valid_b[l]) begin
            assert (ds_dst_tag[l*PREG_WIDTH +: PREG_WIDTH] != ds_src_tag_b[l*PREG_WIDTH +: PREG_WIDTH]);
          end
        end
      end
    end
    if (!rst) begin
      assert (occupancy <= (PTR_WIDTH+1)'(ENTRY_NUM));
    end
  end
endmodule
